// File: rtl/bfp_compress_blk_pkg.sv
// Shared constants, types and exponent helper for the PUSCH block-floating-point compressor.
// Sample and mantissa widths are fixed here; the block length stays a top-level parameter.
package pusch_bfp_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int CMPR_WIDTH  = 7;
  localparam int SHIFT_WIDTH = 4;
  localparam int MAX_EXP     = DATA_WIDTH - CMPR_WIDTH;
  localparam int MANT_MAX    = 63;
  localparam int MANT_MIN    = -64;

  typedef logic [SHIFT_WIDTH-1:0] agc_t;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_BUSY = 1'b1
  } rd_state_e;

  // Shift needed so that the highest magnitude bit of m lands on mantissa bit 5.
  function automatic agc_t exp_from_mask(input logic [DATA_WIDTH-2:0] m);
    agc_t e;
    e = {SHIFT_WIDTH{1'b0}};
    for (int i = CMPR_WIDTH - 1; i < DATA_WIDTH - 1; i++) begin
      if (m[i]) begin
        e = agc_t'(i - (CMPR_WIDTH - 2));
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/bfp_compress_blk_exp_detect.sv
// Per-block magnitude OR accumulator and priority encoder; registers the block AGC code
// and pulses done_o on the clock edge that accepts the last sample of a block.
module bfp_exp_detect
  import pusch_bfp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vld_i,
  input  logic                  first_i,
  input  logic                  last_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output agc_t                  agc_o,
  output logic                  done_o
);

  logic [DATA_WIDTH-2:0] acc_q, acc_d, mag_s;
  agc_t                  agc_q, agc_d;
  logic                  done_q, done_d;

  // Accumulate one's-complement magnitudes; a first sample restarts, a last sample closes out.
  always_comb begin
    mag_s  = din_i[DATA_WIDTH-2:0] ^ {(DATA_WIDTH-1){din_i[DATA_WIDTH-1]}};
    acc_d  = acc_q;
    agc_d  = agc_q;
    done_d = 1'b0;
    if (vld_i) begin
      if (first_i) begin
        acc_d = mag_s;
      end else if (last_i) begin
        acc_d  = {(DATA_WIDTH-1){1'b0}};
        agc_d  = agc_t'(MAX_EXP) - exp_from_mask(acc_q | mag_s);
        done_d = 1'b1;
      end else begin
        acc_d = acc_q | mag_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Detector state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= {(DATA_WIDTH-1){1'b0}};
      agc_q  <= {SHIFT_WIDTH{1'b0}};
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      agc_q  <= agc_d;
      done_q <= done_d;
    end
  end

  assign agc_o  = agc_q;
  assign done_o = done_q;

endmodule

// File: rtl/bfp_compress_blk.sv
// Block-floating-point compressor: ping-pong sample buffer, shared-exponent detection and
// mantissa read-out. Define CMPR_ROUND_EN for round-half-up mantissas with saturation.
module bfp_compress_blk
  import pusch_bfp_pkg::*;
#(
  parameter int BLOCK_LEN = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic                  i_sop,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic                  o_valid,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic [CMPR_WIDTH-1:0] o_dout,
  output agc_t                  o_agc,
  output logic                  o_err
);

  localparam int CNT_W  = $clog2(BLOCK_LEN);
  localparam int DEPTH  = 2 * BLOCK_LEN;
  localparam int ADDR_W = $clog2(DEPTH);

  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  err_q, err_d;
  logic                  wr_en_s, wr_first_s, wr_last_s;
  logic [CNT_W-1:0]      wr_idx_s;
  logic [ADDR_W-1:0]     wr_addr_s, rd_addr_s;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_s;
  agc_t                  det_agc_s;
  logic                  det_done_s;

  rd_state_e             rd_state_q, rd_state_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic                  rd_bank_q, rd_bank_d;
  agc_t                  rd_agc_q, rd_agc_d;
  agc_t                  rd_exp_s;
  logic [CMPR_WIDTH-1:0] mant_s;

  logic                  valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [CMPR_WIDTH-1:0] dout_q, dout_d;
  agc_t                  agc_q, agc_d;

  // Write sequencing: sop always (re)starts at index 0 of the current bank, dropping a partial block.
  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    err_d      = 1'b0;
    wr_en_s    = 1'b0;
    wr_first_s = 1'b0;
    wr_last_s  = 1'b0;
    wr_idx_s   = wr_cnt_q;
    if (i_valid && i_sop) begin
      wr_en_s    = 1'b1;
      wr_first_s = 1'b1;
      wr_idx_s   = {CNT_W{1'b0}};
      wr_cnt_d   = CNT_W'(1);
      err_d      = (wr_cnt_q != {CNT_W{1'b0}});
    end else if (i_valid && (wr_cnt_q != {CNT_W{1'b0}})) begin
      wr_en_s = 1'b1;
      if (wr_cnt_q == CNT_W'(BLOCK_LEN - 1)) begin
        wr_last_s = 1'b1;
        wr_cnt_d  = {CNT_W{1'b0}};
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    wr_addr_s = (wr_bank_q ? ADDR_W'(BLOCK_LEN) : {ADDR_W{1'b0}}) + ADDR_W'(wr_idx_s);
  end

  // Write-side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q  <= {CNT_W{1'b0}};
      wr_bank_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      err_q     <= err_d;
    end
  end

  // Ping-pong sample storage.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= i_din;
    end
  end

  bfp_exp_detect u_exp_detect (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_i   (wr_en_s),
    .first_i (wr_first_s),
    .last_i  (wr_last_s),
    .din_i   (i_din),
    .agc_o   (det_agc_s),
    .done_o  (det_done_s)
  );

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      rd_cnt_q   <= {CNT_W{1'b0}};
      rd_bank_q  <= 1'b0;
      rd_agc_q   <= {SHIFT_WIDTH{1'b0}};
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_bank_q  <= rd_bank_d;
      rd_agc_q   <= rd_agc_d;
    end
  end

  // Read FSM next state; a handover coincides at most with the final read of the previous block.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_bank_d  = rd_bank_q;
    rd_agc_d   = rd_agc_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (det_done_s) begin
          rd_state_d = RD_BUSY;
          rd_cnt_d   = {CNT_W{1'b0}};
          rd_bank_d  = ~wr_bank_q;
          rd_agc_d   = det_agc_s;
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      RD_BUSY: begin
        if (det_done_s) begin
          rd_state_d = RD_BUSY;
          rd_cnt_d   = {CNT_W{1'b0}};
          rd_bank_d  = ~wr_bank_q;
          rd_agc_d   = det_agc_s;
        end else if (rd_cnt_q == CNT_W'(BLOCK_LEN - 1)) begin
          rd_state_d = RD_IDLE;
          rd_cnt_d   = {CNT_W{1'b0}};
        end else begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
        rd_cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign rd_addr_s = (rd_bank_q ? ADDR_W'(BLOCK_LEN) : {ADDR_W{1'b0}}) + ADDR_W'(rd_cnt_q);
  assign rd_data_s = mem_q[rd_addr_s];
  assign rd_exp_s  = agc_t'(MAX_EXP) - rd_agc_q;

`ifdef CMPR_ROUND_EN
  logic [DATA_WIDTH:0] rnd_s, sum_s;
  logic [CMPR_WIDTH:0] sh_s;
  logic [4:0]          ridx_s;

  // Round half up, then saturate the single overflow case (+64) to the mantissa range.
  always_comb begin
    if (rd_exp_s == {SHIFT_WIDTH{1'b0}}) begin
      rnd_s = {(DATA_WIDTH+1){1'b0}};
    end else begin
      rnd_s = (DATA_WIDTH+1)'(1) << (rd_exp_s - agc_t'(1));
    end
    sum_s  = {rd_data_s[DATA_WIDTH-1], rd_data_s} + rnd_s;
    sh_s   = {(CMPR_WIDTH+1){1'b0}};
    ridx_s = 5'd0;
    for (int k = 0; k <= CMPR_WIDTH; k++) begin
      ridx_s  = 5'(k) + {1'b0, rd_exp_s};
      sh_s[k] = sum_s[ridx_s];
    end
    if (!sh_s[CMPR_WIDTH] && sh_s[CMPR_WIDTH-1]) begin
      mant_s = CMPR_WIDTH'(MANT_MAX);
    end else if (sh_s[CMPR_WIDTH] && !sh_s[CMPR_WIDTH-1]) begin
      mant_s = CMPR_WIDTH'(MANT_MIN);
    end else begin
      mant_s = sh_s[CMPR_WIDTH-1:0];
    end
  end
`else
  agc_t bidx_s;

  // Arithmetic shift right by e, picking only the bits that land in the mantissa.
  always_comb begin
    mant_s = {CMPR_WIDTH{1'b0}};
    bidx_s = {SHIFT_WIDTH{1'b0}};
    for (int k = 0; k < CMPR_WIDTH; k++) begin
      bidx_s    = agc_t'(k) + rd_exp_s;
      mant_s[k] = rd_data_s[bidx_s];
    end
  end
`endif

  // Output stage next values; everything is forced to zero between blocks.
  always_comb begin
    if (rd_state_q == RD_BUSY) begin
      valid_d = 1'b1;
      sop_d   = (rd_cnt_q == {CNT_W{1'b0}});
      eop_d   = (rd_cnt_q == CNT_W'(BLOCK_LEN - 1));
      dout_d  = mant_s;
      agc_d   = rd_agc_q;
    end else begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      dout_d  = {CMPR_WIDTH{1'b0}};
      agc_d   = {SHIFT_WIDTH{1'b0}};
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      dout_q  <= {CMPR_WIDTH{1'b0}};
      agc_q   <= {SHIFT_WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      dout_q  <= dout_d;
      agc_q   <= agc_d;
    end
  end

  assign o_valid = valid_q;
  assign o_sop   = sop_q;
  assign o_eop   = eop_q;
  assign o_dout  = dout_q;
  assign o_agc   = agc_q;
  assign o_err   = err_q;

endmodule
